param_cache: RTL
================

# param_cache

Parametrised direct-mapped cache between a pipeline stage and a RAM_bubblesort/RAM-style backing memory. It generalises the fixed 4-line instruction/data cache in four ways: configurable width, address and line count, a read-only mode, a flush, and hit/miss counters. The cache sits in stage one as the instruction cache (read-only) and in stage three as the data cache (write-through). Its `odv` output stalls the controller exactly as `i_odv`/`d_odv` do today.

## Interface
- d_width, 16: data word width.
- a_width, 8: address width.
- lines, 4: number of cache lines; power of two, ≥2.
- wr_en, 1: 1 = write-through data cache; 0 = read-only instruction cache.
- cnt_width, 16: width of the hit and miss counters.

Ports:
- g_clk, in, 1: clock; all state changes on the rising edge.
- g_clr, in, 1: asynchronous active-low reset.
- cpu_addr, in, a_width: request address.
- cpu_wdata, in, d_width: write data.
- cpu_rd, in, 1: read request.
- cpu_wr, in, 1: write request. Ignored when wr_en=0.
- flush, in, 1: invalidate all lines.
- cpu_rdata, out, d_width: read data.
- odv, out, 1: output data valid; the request completes this cycle.
- mem_addr, out, a_width: backing-memory address.
- mem_wdata, out, d_width: backing-memory write data.
- mem_rd, out, 1: memory read strobe.
- mem_wr, out, 1: memory write strobe.
- mem_rdata, in, d_width: memory read data.
- mem_ack, in, 1: memory transfer complete.
- hit_cnt, out, cnt_width: saturating hit counter.
- miss_cnt, out, cnt_width: saturating miss counter.

## Operation
- **Address split:** index = cpu_addr[log2(lines)-1:0]; tag = the remaining upper bits. Each line holds a valid bit, a tag and one data word.
- **State machine:** states IDLE, FILL and WRITE.
- **IDLE, read hit:** odv=1 and cpu_rdata = line data, combinationally. hit_cnt increments.
- **IDLE, read miss:** odv=0. Latch addr into mem_addr, increment miss_cnt, go to FILL.
- **IDLE, write (wr_en=1):** odv=0. Latch addr and wdata, go to WRITE. A write that hits updates the line at this edge. A write that misses does not allocate. The counters do not change on writes.
- **IDLE, cpu_rd and cpu_wr both high:** the write takes priority.
- **FILL:** mem_rd=1 until mem_ack. In the ack cycle:
  - odv=1 and cpu_rdata = mem_rdata (forwarded).
  - The line is written valid with the new tag.
  - The next state is IDLE.
- **WRITE:** mem_wr=1 with mem_wdata until mem_ack. In the ack cycle odv=1; the next state is IDLE.
- **Requester obligation:** hold the request stable while odv=0. After sampling odv=1, change or drop the request.
- **No request:** odv=1 and cpu_rdata=0.
- **Flush in IDLE:** all valid bits clear at the edge. odv is forced to 0 that cycle, so any coincident request misses next cycle.
- **Flush in FILL or WRITE:** the flush is registered as pending. It is applied at the edge where mem_ack returns to IDLE, and it also invalidates the line just filled. Forwarded data is still returned with odv=1.
- **Counters:** saturate at all-ones and never wrap. Flush does not clear them.
- **Reset (g_clr=0), at any time including mid-transaction:**
  - state=IDLE; all valid bits, the pending flush and both counters = 0.
  - mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - The memory transaction is abandoned.
- **Outputs after reset with no request:** odv=1, cpu_rdata=0.

## Timing
- Read hit: 0-cycle latency (odv in the request cycle).
- Read miss: request at cycle 0 with odv=0. mem_rd is high from cycle 1. With ack at cycle k, odv=1 at cycle k. The next request is accepted at cycle k+1.
- Write: same shape as a read miss, using mem_wr.
- mem_ack in the same cycle mem_rd or mem_wr first rises (cycle 1) is legal: this is the minimum miss latency of 2 cycles.
- mem_ack while in IDLE is ignored.
- mem_addr, mem_wdata, mem_rd and mem_wr are registered outputs.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'b00, FILL=2'b01, WRITE=2'b10);
  - a clog2 function for the index width.
- One sub-module, `cache_store`: valid/tag/data arrays with a combinational lookup port, one write port, and a global valid-clear. It resets asynchronously on g_clr.
- The FSM, request latch and counters live in `param_cache`.

## Test plan
- **Reset, read miss, read hit:**
  - Stimulus: reset, then read 0x05 with memory returning 0xBEEF after a 3-cycle ack.
  - Required: odv=0 for cycles 0–2; odv=1 with cpu_rdata=0xBEEF at cycle 3; miss_cnt=1.
  - Then a re-read of 0x05 gives odv=1 in the same cycle with data 0xBEEF, and hit_cnt=1.
- **Conflict eviction:**
  - Stimulus: read 0x05, then 0x09 (same index 1), then 0x05.
  - Required: all three miss; miss_cnt=3.
- **Write-through:**
  - Stimulus: write 0x1234 to cached 0x05.
  - Required: mem_wr=1 with mem_addr=0x05, mem_wdata=0x1234.
  - A following read of 0x05 hits with 0x1234.
- **Write miss, no allocate:** a write to uncached 0x22 followed by a read of 0x22 gives a miss.
- **Flush during FILL:**
  - Stimulus: assert flush during a fill of 0x05.
  - Required: forwarded data is still returned with odv=1; the next read of 0x05 misses.
  - With wr_en=0, cpu_wr never raises mem_wr.
- **Reset mid-FILL:**
  - Stimulus: pull g_clr low while mem_rd=1.
  - Required: mem_rd drops without a clock edge and the counters read 0.
  - A read of a previously cached address misses.
  - Counter saturation: force cnt_width=4 and perform 20 hits; hit_cnt holds at 15.

Source files
------------

// File: rtl/param_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_cache_pkg
//  Description : Shared definitions for the parametrised direct-mapped cache:
//                controller state encoding and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package param_cache_pkg;

    // Controller state encoding
    localparam logic [1:0] C_ST_IDLE  = 2'b00;
    localparam logic [1:0] C_ST_FILL  = 2'b01;
    localparam logic [1:0] C_ST_WRITE = 2'b10;

    // Ceiling log2, used to size the line index (lines is a power of two)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_store.sv
`default_nettype none
// ============================================================================
//  Module      : cache_store
//  Description : Valid/tag/data line storage for the direct-mapped cache.
//                Combinational lookup port, one write port, global valid clear.
//  Ports       : g_clk, g_clr (async active-low reset)
//                lk_index/lk_tag -> lk_hit/lk_data   lookup
//                upd_en/upd_index/upd_tag/upd_data   line write (sets valid)
//                clr_all                              clear every valid bit
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_store
    import param_cache_pkg::*;
#(
    parameter int d_width = 16,
    parameter int a_width = 8,
    parameter int lines   = 4,
    localparam int IDX_W  = clog2(lines),
    localparam int TAG_W  = a_width - IDX_W
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic [IDX_W-1:0]   lk_index,
    input  logic [TAG_W-1:0]   lk_tag,
    output logic               lk_hit,
    output logic [d_width-1:0] lk_data,
    input  logic               upd_en,
    input  logic [IDX_W-1:0]   upd_index,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic [d_width-1:0] upd_data,
    input  logic               clr_all
);

    logic [lines-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [lines];
    logic [d_width-1:0] r_data [lines];

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_valid <= '0;
            for (int i = 0; i < lines; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (upd_en) begin
                r_valid[upd_index] <= 1'b1;
                r_tag[upd_index]   <= upd_tag;
                r_data[upd_index]  <= upd_data;
            end
            // Clear is last so it also invalidates a line written this edge
            if (clr_all) begin
                r_valid <= '0;
            end
        end
    end

    assign lk_hit  = r_valid[lk_index] && (r_tag[lk_index] == lk_tag);
    assign lk_data = r_data[lk_index];

endmodule
`default_nettype wire

// File: rtl/param_cache.sv
`default_nettype none
// ============================================================================
//  Module      : param_cache
//  Description : Parametrised direct-mapped cache, read-only or write-through,
//                with flush and saturating hit/miss counters.
//  Ports       : g_clk, g_clr (async active-low reset)
//                cpu_addr/cpu_wdata/cpu_rd/cpu_wr/flush -> cpu_rdata/odv
//                mem_addr/mem_wdata/mem_rd/mem_wr (registered) <- mem_rdata/mem_ack
//                hit_cnt/miss_cnt saturating statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module param_cache
    import param_cache_pkg::*;
#(
    parameter int d_width   = 16,
    parameter int a_width   = 8,
    parameter int lines     = 4,
    parameter bit wr_en     = 1'b1,
    parameter int cnt_width = 16
) (
    input  logic                 g_clk,
    input  logic                 g_clr,
    input  logic [a_width-1:0]   cpu_addr,
    input  logic [d_width-1:0]   cpu_wdata,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic                 flush,
    output logic [d_width-1:0]   cpu_rdata,
    output logic                 odv,
    output logic [a_width-1:0]   mem_addr,
    output logic [d_width-1:0]   mem_wdata,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic [d_width-1:0]   mem_rdata,
    input  logic                 mem_ack,
    output logic [cnt_width-1:0] hit_cnt,
    output logic [cnt_width-1:0] miss_cnt
);

    localparam int IDX_W = clog2(lines);
    localparam int TAG_W = a_width - IDX_W;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [a_width-1:0]   r_mem_addr;
    logic [d_width-1:0]   r_mem_wdata;
    logic                 r_mem_rd;
    logic                 r_mem_wr;
    logic                 r_flush_pend;
    logic [cnt_width-1:0] r_hit_cnt;
    logic [cnt_width-1:0] r_miss_cnt;

    logic                 w_do_wr;
    logic                 w_do_rd;
    logic                 w_hit;
    logic [d_width-1:0]   w_line_data;
    logic                 w_upd_en;
    logic [IDX_W-1:0]     w_upd_index;
    logic [TAG_W-1:0]     w_upd_tag;
    logic [d_width-1:0]   w_upd_data;
    logic                 w_clr_all;
    logic                 w_hit_inc;
    logic                 w_miss_inc;
    logic                 w_issue_rd;
    logic                 w_issue_wr;
    logic                 w_done;

    // Writes win over reads; a read-only cache never sees a write
    assign w_do_wr = cpu_wr & wr_en;
    assign w_do_rd = cpu_rd & ~w_do_wr;

    cache_store #(
        .d_width (d_width),
        .a_width (a_width),
        .lines   (lines)
    ) u_store (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .lk_index  (cpu_addr[IDX_W-1:0]),
        .lk_tag    (cpu_addr[a_width-1:IDX_W]),
        .lk_hit    (w_hit),
        .lk_data   (w_line_data),
        .upd_en    (w_upd_en),
        .upd_index (w_upd_index),
        .upd_tag   (w_upd_tag),
        .upd_data  (w_upd_data),
        .clr_all   (w_clr_all)
    );

    // State register
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a flush in IDLE holds off any coincident request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (!flush) begin
                    if (w_do_wr) begin
                        w_state_nxt = C_ST_WRITE;
                    end else if (w_do_rd && !w_hit) begin
                        w_state_nxt = C_ST_FILL;
                    end
                end
            end
            C_ST_FILL, C_ST_WRITE: begin
                if (mem_ack) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            default: w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        odv         = 1'b0;
        cpu_rdata   = '0;
        w_upd_en    = 1'b0;
        w_upd_index = cpu_addr[IDX_W-1:0];
        w_upd_tag   = cpu_addr[a_width-1:IDX_W];
        w_upd_data  = cpu_wdata;
        w_clr_all   = 1'b0;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        w_issue_rd  = 1'b0;
        w_issue_wr  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                if (flush) begin
                    w_clr_all = 1'b1;
                end else if (w_do_wr) begin
                    w_issue_wr = 1'b1;
                    w_upd_en   = w_hit;     // update on hit, no allocate on miss
                end else if (w_do_rd) begin
                    if (w_hit) begin
                        odv       = 1'b1;
                        cpu_rdata = w_line_data;
                        w_hit_inc = 1'b1;
                    end else begin
                        w_miss_inc = 1'b1;
                        w_issue_rd = 1'b1;
                    end
                end else begin
                    odv = 1'b1;
                end
            end
            C_ST_FILL: begin
                if (mem_ack) begin
                    odv         = 1'b1;
                    cpu_rdata   = mem_rdata;
                    w_upd_en    = 1'b1;
                    w_upd_index = r_mem_addr[IDX_W-1:0];
                    w_upd_tag   = r_mem_addr[a_width-1:IDX_W];
                    w_upd_data  = mem_rdata;
                    w_clr_all   = r_flush_pend | flush;
                    w_done      = 1'b1;
                end
            end
            C_ST_WRITE: begin
                if (mem_ack) begin
                    odv       = 1'b1;
                    w_clr_all = r_flush_pend | flush;
                    w_done    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Memory-side registers, pending flush and statistics
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (w_issue_rd || w_issue_wr) begin
                r_mem_addr <= cpu_addr;
            end
            if (w_issue_wr) begin
                r_mem_wdata <= cpu_wdata;
                r_mem_wr    <= 1'b1;
            end
            if (w_issue_rd) begin
                r_mem_rd <= 1'b1;
            end
            if (w_done) begin
                r_mem_rd     <= 1'b0;
                r_mem_wr     <= 1'b0;
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != C_ST_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            if (w_hit_inc && (r_hit_cnt != {cnt_width{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_inc && (r_miss_cnt != {cnt_width{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

endmodule
`default_nettype wire
